// File: rtl/pl_inv_iter.sv
// pl_inv_iter: iterative inverse of the Ascon linear diffusion layer (Pl).
//
// Each 64-bit word w is recovered with L_w^-1 = L_w^63, which factors into
// L_0 * L_1 * ... * L_5. Each factor has the form
//     L_k(v) = v ^ ror(v, r1*2^k mod 64) ^ ror(v, r2*2^k mod 64).
// STAGES_PER_CYCLE factors are applied per clock to all five words at once.
// All rotation amounts are elaboration-time constants.
//
// Ports:
//   clock_i   - system clock, rising edge
//   resetb_i  - asynchronous active-low reset
//   start_i   - load data_i and begin; honoured in IDLE and DONE only
//   data_i    - 5x64 state to invert, word i = data_i[i]
//   busy_o    - high while an inversion is in progress
//   done_o    - one-cycle pulse when data_o holds a fresh result
//   data_o    - inverted state, held until the next completed job
module pl_inv_iter #(
    parameter int STAGES_PER_CYCLE = 1,
    parameter int NB_STAGES        = 6
) (
    input  logic             clock_i,
    input  logic             resetb_i,
    input  logic             start_i,
    input  logic [4:0][63:0] data_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [4:0][63:0] data_o
);

    // Reject unsupported configurations at elaboration.
    if (!(STAGES_PER_CYCLE == 1 || STAGES_PER_CYCLE == 2 ||
          STAGES_PER_CYCLE == 3 || STAGES_PER_CYCLE == 6) || NB_STAGES != 6) begin : g_bad_cfg
        $error("pl_inv_iter: STAGES_PER_CYCLE must be 1, 2, 3 or 6 and NB_STAGES must be 6");
    end

    localparam int         NB_GROUPS = NB_STAGES / STAGES_PER_CYCLE;
    localparam logic [2:0] STEP      = 3'(STAGES_PER_CYCLE);
    localparam logic [2:0] LAST      = 3'(NB_STAGES);

    // Per-word Pl rotation pairs.
    localparam int R1 [5] = '{19, 61, 1, 10, 7};
    localparam int R2 [5] = '{28, 39, 6, 17, 41};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_e;

    // Rotate right; an amount of 0 yields v because v << 64 is zero.
    function automatic logic [63:0] ror64(input logic [63:0] v, input int amt);
        return (v >> amt) | (v << (64 - amt));
    endfunction

    // Applies factors first_k .. first_k+STAGES_PER_CYCLE-1 to all words.
    // Rotation amounts are constants here because first_k comes from a genvar.
    function automatic logic [4:0][63:0] l_group(input logic [4:0][63:0] v, input int first_k);
        logic [4:0][63:0] acc;
        acc = v;
        for (int j = 0; j < STAGES_PER_CYCLE; j++) begin
            for (int w = 0; w < 5; w++) begin
                acc[w] = acc[w]
                       ^ ror64(acc[w], (R1[w] << (first_k + j)) % 64)
                       ^ ror64(acc[w], (R2[w] << (first_k + j)) % 64);
            end
        end
        return acc;
    endfunction

    fsm_e             fsm_r;
    fsm_e             fsm_nxt_s;
    logic [4:0][63:0] state_r;
    logic [2:0]       cnt_r;
    logic [4:0][63:0] step_s;
    logic [4:0][63:0] grp_s [NB_GROUPS];
    logic             load_s;
    logic             adv_s;
    logic             publish_s;
    logic             busy_nxt_s;
    logic             done_nxt_s;

    for (genvar g = 0; g < NB_GROUPS; g++) begin : g_grp
        assign grp_s[g] = l_group(state_r, g * STAGES_PER_CYCLE);
    end

    // Pick the stage group addressed by the counter (one-hot OR of groups).
    always_comb begin
        step_s = {320{1'b0}};
        for (int g = 0; g < NB_GROUPS; g++) begin
            step_s = step_s | ((cnt_r == 3'(g * STAGES_PER_CYCLE)) ? grp_s[g] : {320{1'b0}});
        end
    end

    // FSM state register.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            fsm_r <= ST_IDLE;
        end else begin
            fsm_r <= fsm_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        fsm_nxt_s = fsm_r;
        case (fsm_r)
            ST_IDLE: fsm_nxt_s = start_i ? ST_RUN : ST_IDLE;
            ST_RUN:  fsm_nxt_s = (cnt_r == LAST) ? ST_DONE : ST_RUN;
            ST_DONE: fsm_nxt_s = start_i ? ST_RUN : ST_IDLE;
            default: fsm_nxt_s = ST_IDLE;
        endcase
    end

    // FSM control outputs; busy/done are precomputed so they can be registered.
    always_comb begin
        load_s     = 1'b0;
        adv_s      = 1'b0;
        publish_s  = 1'b0;
        case (fsm_r)
            ST_IDLE: load_s = start_i;
            ST_RUN: begin
                if (cnt_r == LAST) begin
                    publish_s = 1'b1;
                end else begin
                    adv_s = 1'b1;
                end
            end
            ST_DONE: load_s = start_i;
            default: load_s = 1'b0;
        endcase
        busy_nxt_s = (fsm_nxt_s == ST_RUN);
        done_nxt_s = (fsm_nxt_s == ST_DONE);
    end

    // Datapath: working state, stage counter and registered outputs.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_r <= {320{1'b0}};
            cnt_r   <= 3'd0;
            data_o  <= {320{1'b0}};
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            busy_o <= busy_nxt_s;
            done_o <= done_nxt_s;
            if (load_s) begin
                state_r <= data_i;
                cnt_r   <= 3'd0;
            end else if (adv_s) begin
                state_r <= step_s;
                cnt_r   <= cnt_r + STEP;
            end else begin
                state_r <= state_r;
                cnt_r   <= cnt_r;
            end
            if (publish_s) begin
                data_o <= state_r;
            end else begin
                data_o <= data_o;
            end
        end
    end

endmodule

// File: tb/tb_pl_inv_iter.sv
// Directed bench for pl_inv_iter: four instances (1, 2, 3, 6 stages per
// cycle) share clock, reset and stimulus. Expected results come from a
// forward Pl model and hand-chosen constants.
module tb_pl_inv_iter;

    logic             clk;
    logic             rstb;
    logic             start;
    logic [4:0][63:0] din;
    logic             busy_s [4];
    logic             done_s [4];
    logic [4:0][63:0] dout_s [4];

    int checks   = 0;
    int failures = 0;

    int               lat    [4];
    int               pulses [4];
    logic [4:0][63:0] res    [4];

    logic [4:0][63:0] orig;
    logic [4:0][63:0] ones;
    int               c;

    pl_inv_iter #(.STAGES_PER_CYCLE(1)) u_s1 (.clock_i(clk), .resetb_i(rstb), .start_i(start),
        .data_i(din), .busy_o(busy_s[0]), .done_o(done_s[0]), .data_o(dout_s[0]));
    pl_inv_iter #(.STAGES_PER_CYCLE(2)) u_s2 (.clock_i(clk), .resetb_i(rstb), .start_i(start),
        .data_i(din), .busy_o(busy_s[1]), .done_o(done_s[1]), .data_o(dout_s[1]));
    pl_inv_iter #(.STAGES_PER_CYCLE(3)) u_s3 (.clock_i(clk), .resetb_i(rstb), .start_i(start),
        .data_i(din), .busy_o(busy_s[2]), .done_o(done_s[2]), .data_o(dout_s[2]));
    pl_inv_iter #(.STAGES_PER_CYCLE(6)) u_s6 (.clock_i(clk), .resetb_i(rstb), .start_i(start),
        .data_i(din), .busy_o(busy_s[3]), .done_o(done_s[3]), .data_o(dout_s[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] rr(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    // Forward Ascon linear layer.
    function automatic logic [4:0][63:0] pl(input logic [4:0][63:0] x);
        logic [4:0][63:0] y;
        y[0] = x[0] ^ rr(x[0], 19) ^ rr(x[0], 28);
        y[1] = x[1] ^ rr(x[1], 61) ^ rr(x[1], 39);
        y[2] = x[2] ^ rr(x[2], 1)  ^ rr(x[2], 6);
        y[3] = x[3] ^ rr(x[3], 10) ^ rr(x[3], 17);
        y[4] = x[4] ^ rr(x[4], 7)  ^ rr(x[4], 41);
        return y;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start a job on all instances and watch 12 cycles for each done pulse.
    task automatic run_job(input logic [4:0][63:0] v);
        din   = v;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            lat[i]    = -1;
            pulses[i] = 0;
            res[i]    = {320{1'b0}};
        end
        for (int cyc = 1; cyc <= 12; cyc++) begin
            tick();
            for (int i = 0; i < 4; i++) begin
                if (done_s[i]) begin
                    pulses[i]++;
                    if (lat[i] < 0) begin
                        lat[i] = cyc;
                        res[i] = dout_s[i];
                    end
                end
            end
        end
    endtask

    initial begin
        orig[0] = 64'h80400c0600000000;
        orig[1] = 64'h8a55114d1cb6a9a2;
        orig[2] = 64'hbe263d4d7aecaaff;
        orig[3] = 64'h4ed0ec0b98c529b7;
        orig[4] = 64'hc8cddf37bcd0284a;
        ones    = {320{1'b1}};

        rstb  = 1'b0;
        start = 1'b0;
        din   = {320{1'b0}};
        tick();
        tick();
        chk("reset_outputs", {busy_s[0], done_s[0], dout_s[0]}, 322'd0);
        rstb = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_outputs", {busy_s[0], done_s[0], dout_s[0]}, 322'd0);
        end

        // Zero state.
        run_job({320{1'b0}});
        chk("zero_lat", lat[0], 7);
        chk("zero_data", res[0], 320'd0);
        chk("zero_single_pulse", pulses[0], 1);

        // All-ones is a fixed point.
        run_job(ones);
        chk("ones_lat", lat[0], 7);
        chk("ones_data", res[0], ones);
        chk("ones_held", dout_s[0], ones);

        // Round trip through the forward model for every configuration.
        run_job(pl(orig));
        chk("rt_s1_lat", lat[0], 7);
        chk("rt_s2_lat", lat[1], 4);
        chk("rt_s3_lat", lat[2], 3);
        chk("rt_s6_lat", lat[3], 2);
        chk("rt_s1_data", res[0], orig);
        chk("rt_s2_data", res[1], orig);
        chk("rt_s3_data", res[2], orig);
        chk("rt_s6_data", res[3], orig);
        chk("rt_s6_single_pulse", pulses[3], 1);

        // Start held high during RUN with different data must be ignored.
        din   = pl(orig);
        start = 1'b1;
        tick();
        din = ones;
        c   = 0;
        while (!done_s[0] && c < 12) begin
            tick();
            c++;
        end
        chk("hold_lat", c, 7);
        chk("hold_data", dout_s[0], orig);
        // Still high in DONE: accepted with no idle bubble.
        tick();
        start = 1'b0;
        chk("b2b_busy", busy_s[0], 1'b1);
        c = 0;
        while (!done_s[0] && c < 12) begin
            tick();
            c++;
        end
        chk("b2b_lat", c, 7);
        chk("b2b_data", dout_s[0], ones);

        // Asynchronous reset in the middle of RUN.
        tick();
        din   = pl(orig);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("midrun_busy", busy_s[0], 1'b1);
        #2;
        rstb = 1'b0;
        #1;
        chk("async_reset_outputs", {busy_s[0], done_s[0], dout_s[0]}, 322'd0);
        tick();
        tick();
        rstb = 1'b1;
        c    = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done_s[0] || busy_s[0]) c++;
        end
        chk("after_abort_quiet", c, 0);
        chk("after_abort_data", dout_s[0], 320'd0);
        run_job(pl(orig));
        chk("after_abort_lat", lat[0], 7);
        chk("after_abort_data_rt", res[0], orig);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
